// File: rtl/reorder_buffer.sv
// reorder_buffer: circular reorder buffer between the register file and the
// reservation stations. Allocates one entry per dispatch, resolves pending
// operands from completed entries or same-cycle FU writeback, and retires
// completed entries in program order, one per cycle.
// Ports:
//   in_clk, in_rst            clock, asynchronous active-high reset
//   in_reg_*                  dispatch from the register file
//   in_fu_*                   functional-unit writeback
//   out_next_rob_index        tail entry handed to the current dispatch
//   out_full                  ROB holds ROB_SIZE entries; decode must stall
//   out_rs_*                  registered, operand-resolved dispatch to RS
//   out_commit_*              registered in-order retirement to the regfile
module reorder_buffer #(
    parameter int unsigned ROB_SIZE     = 8,
    parameter int unsigned ROB_IDX_SIZE = 3,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned GPR_IDX_SIZE = 5
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_reg_done,
    input  logic [GPR_IDX_SIZE-1:0] in_reg_dst,
    input  logic                    in_reg_set_nzcv,
    input  logic                    in_reg_uses_nzcv,
    input  logic                    in_reg_src1_valid,
    input  logic [DATA_W-1:0]       in_reg_src1_value,
    input  logic [ROB_IDX_SIZE-1:0] in_reg_src1_rob_index,
    input  logic                    in_reg_src2_valid,
    input  logic [DATA_W-1:0]       in_reg_src2_value,
    input  logic [ROB_IDX_SIZE-1:0] in_reg_src2_rob_index,
    input  logic                    in_reg_nzcv_valid,
    input  logic [3:0]              in_reg_nzcv,
    input  logic [ROB_IDX_SIZE-1:0] in_reg_nzcv_rob_idx,
    input  logic                    in_fu_done,
    input  logic [ROB_IDX_SIZE-1:0] in_fu_rob_index,
    input  logic [DATA_W-1:0]       in_fu_value,
    input  logic [3:0]              in_fu_nzcv,
    output logic [ROB_IDX_SIZE-1:0] out_next_rob_index,
    output logic                    out_full,
    output logic                    out_rs_done,
    output logic [ROB_IDX_SIZE-1:0] out_rs_rob_index,
    output logic                    out_rs_src1_valid,
    output logic [DATA_W-1:0]       out_rs_src1_value,
    output logic [ROB_IDX_SIZE-1:0] out_rs_src1_rob_index,
    output logic                    out_rs_src2_valid,
    output logic [DATA_W-1:0]       out_rs_src2_value,
    output logic [ROB_IDX_SIZE-1:0] out_rs_src2_rob_index,
    output logic                    out_rs_nzcv_valid,
    output logic [3:0]              out_rs_nzcv,
    output logic [ROB_IDX_SIZE-1:0] out_rs_nzcv_rob_index,
    output logic                    out_commit_done,
    output logic [ROB_IDX_SIZE-1:0] out_commit_rob_index,
    output logic [GPR_IDX_SIZE-1:0] out_commit_reg_index,
    output logic [DATA_W-1:0]       out_commit_value,
    output logic                    out_commit_set_nzcv,
    output logic [3:0]              out_commit_nzcv
);

    localparam int unsigned CNT_W = ROB_IDX_SIZE + 1;

    // Per-entry state
    logic [ROB_SIZE-1:0]     alloc_q;
    logic [ROB_SIZE-1:0]     done_q;
    logic [ROB_SIZE-1:0]     set_nzcv_q;
    logic [GPR_IDX_SIZE-1:0] dst_q   [ROB_SIZE];
    logic [DATA_W-1:0]       value_q [ROB_SIZE];
    logic [3:0]              nzcv_q  [ROB_SIZE];

    logic [ROB_IDX_SIZE-1:0] head_q, head_d;
    logic [ROB_IDX_SIZE-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic accept_c, commit_c, wb_c;
    logic              src1_valid_c, src2_valid_c, nzcv_valid_c;
    logic [DATA_W-1:0] src1_value_c, src2_value_c;
    logic [3:0]        nzcv_c;

    assign out_full           = (count_q == CNT_W'(ROB_SIZE));
    assign out_next_rob_index = tail_q;
    assign accept_c = in_reg_done & ~out_full;
    assign commit_c = alloc_q[head_q] & done_q[head_q];
    // Writebacks to unallocated entries are dropped
    assign wb_c     = in_fu_done & alloc_q[in_fu_rob_index];

    // Operand resolution: input value, then completed entry, then same-cycle writeback
    always_comb begin
        src1_valid_c = in_reg_src1_valid;
        src1_value_c = in_reg_src1_value;
        if (!in_reg_src1_valid) begin
            if (done_q[in_reg_src1_rob_index]) begin
                src1_valid_c = 1'b1;
                src1_value_c = value_q[in_reg_src1_rob_index];
            end else if (in_fu_done && (in_fu_rob_index == in_reg_src1_rob_index)) begin
                src1_valid_c = 1'b1;
                src1_value_c = in_fu_value;
            end
        end

        src2_valid_c = in_reg_src2_valid;
        src2_value_c = in_reg_src2_value;
        if (!in_reg_src2_valid) begin
            if (done_q[in_reg_src2_rob_index]) begin
                src2_valid_c = 1'b1;
                src2_value_c = value_q[in_reg_src2_rob_index];
            end else if (in_fu_done && (in_fu_rob_index == in_reg_src2_rob_index)) begin
                src2_valid_c = 1'b1;
                src2_value_c = in_fu_value;
            end
        end

        nzcv_valid_c = in_reg_nzcv_valid;
        nzcv_c       = in_reg_nzcv;
        if (in_reg_uses_nzcv && !in_reg_nzcv_valid) begin
            if (done_q[in_reg_nzcv_rob_idx]) begin
                nzcv_valid_c = 1'b1;
                nzcv_c       = nzcv_q[in_reg_nzcv_rob_idx];
            end else if (in_fu_done && (in_fu_rob_index == in_reg_nzcv_rob_idx)) begin
                nzcv_valid_c = 1'b1;
                nzcv_c       = in_fu_nzcv;
            end
        end
    end

    // Pointer and occupancy next state
    always_comb begin
        head_d  = head_q + ROB_IDX_SIZE'(commit_c);
        tail_d  = tail_q + ROB_IDX_SIZE'(accept_c);
        count_d = count_q + CNT_W'(accept_c) - CNT_W'(commit_c);
    end

    // Pointers, entry control bits and registered outputs
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            head_q                <= '0;
            tail_q                <= '0;
            count_q               <= '0;
            alloc_q               <= '0;
            done_q                <= '0;
            out_rs_done           <= 1'b0;
            out_rs_rob_index      <= '0;
            out_rs_src1_valid     <= 1'b0;
            out_rs_src1_value     <= '0;
            out_rs_src1_rob_index <= '0;
            out_rs_src2_valid     <= 1'b0;
            out_rs_src2_value     <= '0;
            out_rs_src2_rob_index <= '0;
            out_rs_nzcv_valid     <= 1'b0;
            out_rs_nzcv           <= '0;
            out_rs_nzcv_rob_index <= '0;
            out_commit_done       <= 1'b0;
            out_commit_rob_index  <= '0;
            out_commit_reg_index  <= '0;
            out_commit_value      <= '0;
            out_commit_set_nzcv   <= 1'b0;
            out_commit_nzcv       <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;

            // head==tail with a commit pending implies full, so alloc and clear never collide
            if (commit_c) alloc_q[head_q] <= 1'b0;
            if (accept_c) begin
                alloc_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
            end
            if (wb_c) done_q[in_fu_rob_index] <= 1'b1;

            out_rs_done <= accept_c;
            if (accept_c) begin
                out_rs_rob_index      <= tail_q;
                out_rs_src1_valid     <= src1_valid_c;
                out_rs_src1_value     <= src1_value_c;
                out_rs_src1_rob_index <= in_reg_src1_rob_index;
                out_rs_src2_valid     <= src2_valid_c;
                out_rs_src2_value     <= src2_value_c;
                out_rs_src2_rob_index <= in_reg_src2_rob_index;
                out_rs_nzcv_valid     <= nzcv_valid_c;
                out_rs_nzcv           <= nzcv_c;
                out_rs_nzcv_rob_index <= in_reg_nzcv_rob_idx;
            end

            out_commit_done <= commit_c;
            if (commit_c) begin
                out_commit_rob_index <= head_q;
                out_commit_reg_index <= dst_q[head_q];
                out_commit_value     <= value_q[head_q];
                out_commit_set_nzcv  <= set_nzcv_q[head_q];
                out_commit_nzcv      <= nzcv_q[head_q];
            end
        end
    end

    // Entry payload; qualified by alloc/done so it needs no reset
    always_ff @(posedge in_clk) begin
        if (accept_c) begin
            dst_q[tail_q]      <= in_reg_dst;
            set_nzcv_q[tail_q] <= in_reg_set_nzcv;
        end
        if (wb_c) begin
            value_q[in_fu_rob_index] <= in_fu_value;
            nzcv_q[in_fu_rob_index]  <= in_fu_nzcv;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_done = 1'b0;
    logic [4:0]  reg_dst = '0;
    logic        reg_set_nzcv = 1'b0, reg_uses_nzcv = 1'b0;
    logic        s1_valid = 1'b0, s2_valid = 1'b0, n_valid = 1'b0;
    logic [63:0] s1_value = '0, s2_value = '0;
    logic [2:0]  s1_tag = '0, s2_tag = '0, n_tag = '0;
    logic [3:0]  n_value = '0;
    logic        fu_done = 1'b0;
    logic [2:0]  fu_idx = '0;
    logic [63:0] fu_value = '0;
    logic [3:0]  fu_nzcv = '0;

    logic [2:0]  next_idx;
    logic        full;
    logic        rs_done;
    logic [2:0]  rs_idx;
    logic        rs_s1_valid, rs_s2_valid, rs_n_valid;
    logic [63:0] rs_s1_value, rs_s2_value;
    logic [2:0]  rs_s1_tag, rs_s2_tag, rs_n_tag;
    logic [3:0]  rs_nzcv;
    logic        c_done;
    logic [2:0]  c_idx;
    logic [4:0]  c_reg;
    logic [63:0] c_value;
    logic        c_set_nzcv;
    logic [3:0]  c_nzcv;

    int checks = 0;
    int errors = 0;

    reorder_buffer dut (
        .in_clk(clk), .in_rst(rst),
        .in_reg_done(reg_done), .in_reg_dst(reg_dst),
        .in_reg_set_nzcv(reg_set_nzcv), .in_reg_uses_nzcv(reg_uses_nzcv),
        .in_reg_src1_valid(s1_valid), .in_reg_src1_value(s1_value), .in_reg_src1_rob_index(s1_tag),
        .in_reg_src2_valid(s2_valid), .in_reg_src2_value(s2_value), .in_reg_src2_rob_index(s2_tag),
        .in_reg_nzcv_valid(n_valid), .in_reg_nzcv(n_value), .in_reg_nzcv_rob_idx(n_tag),
        .in_fu_done(fu_done), .in_fu_rob_index(fu_idx), .in_fu_value(fu_value), .in_fu_nzcv(fu_nzcv),
        .out_next_rob_index(next_idx), .out_full(full),
        .out_rs_done(rs_done), .out_rs_rob_index(rs_idx),
        .out_rs_src1_valid(rs_s1_valid), .out_rs_src1_value(rs_s1_value), .out_rs_src1_rob_index(rs_s1_tag),
        .out_rs_src2_valid(rs_s2_valid), .out_rs_src2_value(rs_s2_value), .out_rs_src2_rob_index(rs_s2_tag),
        .out_rs_nzcv_valid(rs_n_valid), .out_rs_nzcv(rs_nzcv), .out_rs_nzcv_rob_index(rs_n_tag),
        .out_commit_done(c_done), .out_commit_rob_index(c_idx), .out_commit_reg_index(c_reg),
        .out_commit_value(c_value), .out_commit_set_nzcv(c_set_nzcv), .out_commit_nzcv(c_nzcv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [4:0] dst, input logic set_n,
                            input logic v1, input logic [63:0] d1, input logic [2:0] t1,
                            input logic v2, input logic [63:0] d2, input logic [2:0] t2,
                            input logic uses, input logic vn, input logic [3:0] dn,
                            input logic [2:0] tn);
        reg_done = 1'b1; reg_dst = dst; reg_set_nzcv = set_n;
        s1_valid = v1; s1_value = d1; s1_tag = t1;
        s2_valid = v2; s2_value = d2; s2_tag = t2;
        reg_uses_nzcv = uses; n_valid = vn; n_value = dn; n_tag = tn;
    endtask

    task automatic idle();
        reg_done = 1'b0;
    endtask

    task automatic fu(input logic [2:0] idx, input logic [63:0] val, input logic [3:0] nz);
        fu_done = 1'b1; fu_idx = idx; fu_value = val; fu_nzcv = nz;
    endtask

    task automatic fu_off();
        fu_done = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_rs_done", 64'(rs_done), 64'd0);
        chk("rst_commit_done", 64'(c_done), 64'd0);
        chk("rst_next_idx", 64'(next_idx), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        tick(); tick();
        rst = 1'b0;

        // C1: entry0, dst X1, ready operands
        dispatch(5'd1, 1'b1, 1'b1, 64'd100, 3'd0, 1'b1, 64'd200, 3'd0, 1'b0, 1'b0, 4'd0, 3'd0);
        tick();
        chk("c1_rs_done", 64'(rs_done), 64'd1);
        chk("c1_rs_idx", 64'(rs_idx), 64'd0);
        chk("c1_src1", rs_s1_value, 64'd100);
        chk("c1_src2", rs_s2_value, 64'd200);

        // C2: entry1 waits on tag0 while FU completes entry0 in the same cycle
        dispatch(5'd2, 1'b0, 1'b0, 64'd0, 3'd0, 1'b1, 64'd7, 3'd0, 1'b0, 1'b0, 4'd0, 3'd0);
        fu(3'd0, 64'd42, 4'h5);
        tick();
        chk("c2_rs_idx", 64'(rs_idx), 64'd1);
        chk("c2_src1_valid", 64'(rs_s1_valid), 64'd1);
        chk("c2_src1_fwd", rs_s1_value, 64'd42);

        // C3: entry2; entry0 retires
        dispatch(5'd3, 1'b0, 1'b1, 64'd1, 3'd0, 1'b1, 64'd2, 3'd0, 1'b0, 1'b0, 4'd0, 3'd0);
        fu_off();
        tick();
        chk("c3_rs_idx", 64'(rs_idx), 64'd2);
        chk("c3_next_idx", 64'(next_idx), 64'd3);
        chk("c3_commit_done", 64'(c_done), 64'd1);
        chk("c3_commit_idx", 64'(c_idx), 64'd0);
        chk("c3_commit_reg", 64'(c_reg), 64'd1);
        chk("c3_commit_val", c_value, 64'd42);
        chk("c3_commit_setn", 64'(c_set_nzcv), 64'd1);
        chk("c3_commit_nzcv", 64'(c_nzcv), 64'h5);

        // C4: entry2 completes out of order; head (entry1) not done
        idle();
        fu(3'd2, 64'd22, 4'h2);
        tick();
        chk("c4_rs_done", 64'(rs_done), 64'd0);
        chk("c4_commit_done", 64'(c_done), 64'd0);

        // C5: entry3 resolves src1 from done entry2, src2 from FU, flags from done entry0
        dispatch(5'd4, 1'b0, 1'b0, 64'd0, 3'd2, 1'b0, 64'd0, 3'd1, 1'b1, 1'b0, 4'd0, 3'd0);
        fu(3'd1, 64'd11, 4'h3);
        tick();
        chk("c5_rs_idx", 64'(rs_idx), 64'd3);
        chk("c5_src1_valid", 64'(rs_s1_valid), 64'd1);
        chk("c5_src1_entry", rs_s1_value, 64'd22);
        chk("c5_src2_valid", 64'(rs_s2_valid), 64'd1);
        chk("c5_src2_fwd", rs_s2_value, 64'd11);
        chk("c5_nzcv_valid", 64'(rs_n_valid), 64'd1);
        chk("c5_nzcv", 64'(rs_nzcv), 64'h5);
        chk("c5_commit_done", 64'(c_done), 64'd0);

        // C6: entry4 waits on unresolved tag3; entry1 retires
        dispatch(5'd5, 1'b0, 1'b0, 64'd0, 3'd3, 1'b1, 64'd9, 3'd0, 1'b0, 1'b0, 4'd0, 3'd0);
        fu_off();
        tick();
        chk("c6_rs_idx", 64'(rs_idx), 64'd4);
        chk("c6_src1_valid", 64'(rs_s1_valid), 64'd0);
        chk("c6_src1_tag", 64'(rs_s1_tag), 64'd3);
        chk("c6_commit_idx", 64'(c_idx), 64'd1);
        chk("c6_commit_val", c_value, 64'd11);
        chk("c6_commit_reg", 64'(c_reg), 64'd2);
        chk("c6_commit_nzcv", 64'(c_nzcv), 64'h3);

        // C7: entry2 retires
        idle();
        tick();
        chk("c7_commit_done", 64'(c_done), 64'd1);
        chk("c7_commit_idx", 64'(c_idx), 64'd2);
        chk("c7_commit_val", c_value, 64'd22);

        // C8..C11: drain entries 3 and 4
        fu(3'd3, 64'd33, 4'h0);
        tick();
        chk("c8_commit_done", 64'(c_done), 64'd0);
        fu(3'd4, 64'd44, 4'h0);
        tick();
        chk("c9_commit_idx", 64'(c_idx), 64'd3);
        chk("c9_commit_val", c_value, 64'd33);
        fu_off();
        tick();
        chk("c10_commit_idx", 64'(c_idx), 64'd4);
        chk("c10_commit_val", c_value, 64'd44);
        tick();
        chk("c11_commit_done", 64'(c_done), 64'd0);
        chk("c11_next_idx", 64'(next_idx), 64'd5);

        // Fill to capacity
        pulse_reset();
        chk("fill_start_idx", 64'(next_idx), 64'd0);
        for (int i = 0; i < 8; i++) begin
            dispatch(5'(i + 1), 1'b0, 1'b1, 64'(i), 3'd0, 1'b1, 64'd0, 3'd0, 1'b0, 1'b0, 4'd0, 3'd0);
            tick();
            chk("fill_rs_idx", 64'(rs_idx), 64'(i));
            chk("fill_full", 64'(full), (i == 7) ? 64'd1 : 64'd0);
        end
        chk("fill_next_idx", 64'(next_idx), 64'd0);
        // Dispatch while full is dropped
        tick();
        chk("ovf_rs_done", 64'(rs_done), 64'd0);
        chk("ovf_next_idx", 64'(next_idx), 64'd0);
        chk("ovf_full", 64'(full), 64'd1);
        idle();
        fu(3'd0, 64'hAA, 4'h9);
        tick();
        chk("fullwb_full", 64'(full), 64'd1);
        chk("fullwb_commit", 64'(c_done), 64'd0);
        fu_off();
        tick();
        chk("fullc_commit_done", 64'(c_done), 64'd1);
        chk("fullc_commit_idx", 64'(c_idx), 64'd0);
        chk("fullc_commit_val", c_value, 64'hAA);
        chk("fullc_full", 64'(full), 64'd0);
        dispatch(5'd20, 1'b0, 1'b1, 64'd0, 3'd0, 1'b1, 64'd0, 3'd0, 1'b0, 1'b0, 4'd0, 3'd0);
        tick();
        chk("refill_rs_idx", 64'(rs_idx), 64'd0);
        chk("refill_full", 64'(full), 64'd1);
        idle();

        // Stream of 12 dispatch+complete with wrap-around
        pulse_reset();
        for (int i = 0; i < 14; i++) begin
            if (i < 12) dispatch(5'(i + 1), 1'b0, 1'b1, 64'd0, 3'd0, 1'b1, 64'd0, 3'd0,
                                 1'b0, 1'b0, 4'd0, 3'd0);
            else idle();
            if (i >= 1 && i <= 12) fu(3'(i - 1), 64'(1000 + i - 1), 4'h0);
            else fu_off();
            tick();
            if (i < 12) chk("strm_rs_idx", 64'(rs_idx), 64'(i % 8));
            chk("strm_commit_done", 64'(c_done), (i >= 2) ? 64'd1 : 64'd0);
            if (i >= 2) begin
                chk("strm_commit_idx", 64'(c_idx), 64'((i - 2) % 8));
                chk("strm_commit_val", c_value, 64'(1000 + i - 2));
                chk("strm_commit_reg", 64'(c_reg), 64'(i - 1));
            end
        end
        tick();
        chk("strm_end_commit", 64'(c_done), 64'd0);
        chk("strm_end_full", 64'(full), 64'd0);
        chk("strm_end_idx", 64'(next_idx), 64'd4);

        // Reset mid-stream with 4 in flight
        for (int i = 0; i < 5; i++) begin
            dispatch(5'(i + 1), 1'b0, 1'b1, 64'hF0, 3'd0, 1'b1, 64'd0, 3'd0, 1'b0, 1'b0, 4'd0, 3'd0);
            if (i == 3) fu(3'd4, 64'd77, 4'h1);
            else if (i == 4) fu(3'd5, 64'd88, 4'h1);
            else fu_off();
            tick();
        end
        idle();
        fu_off();
        chk("pre_rst_rs_done", 64'(rs_done), 64'd1);
        chk("pre_rst_commit", 64'(c_done), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rs_done", 64'(rs_done), 64'd0);
        chk("mid_rst_rs_idx", 64'(rs_idx), 64'd0);
        chk("mid_rst_src1", rs_s1_value, 64'd0);
        chk("mid_rst_commit", 64'(c_done), 64'd0);
        chk("mid_rst_cval", c_value, 64'd0);
        chk("mid_rst_next_idx", 64'(next_idx), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_commit", 64'(c_done), 64'd0);
            chk("post_rst_next_idx", 64'(next_idx), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
